// File: rtl/timer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : timer_sequencer
// Purpose  : Command-driven timer controller that reports match, overflow,
//            timeout and illegal-command events through a 2-entry FIFO.
// Revision : 1.0
// ============================================================================
module timer_sequencer #(
    parameter int TIMER_WIDTH    = 32,
    parameter int CNT_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_op,
    input  logic [TIMER_WIDTH-1:0] cmd_data,
    output logic [TIMER_WIDTH-1:0] timer_load,
    output logic                   timer_start,
    output logic                   timer_stop,
    output logic                   timer_pause,
    input  logic [TIMER_WIDTH-1:0] timer_value,
    input  logic                   timer_active,
    input  logic                   timer_match,
    input  logic                   timer_overflow,
    output logic                   evt_valid,
    input  logic                   evt_ready,
    output logic [1:0]             evt_code,
    output logic [TIMER_WIDTH-1:0] evt_value,
    output logic [CNT_WIDTH-1:0]   match_count,
    output logic [CNT_WIDTH-1:0]   ovf_count,
    output logic                   evt_lost
);

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_WAIT_ACT = 3'd1;
    localparam logic [2:0] c_RUNNING  = 3'd2;
    localparam logic [2:0] c_PAUSED   = 3'd3;
    localparam logic [2:0] c_STOPPING = 3'd4;

    localparam logic [1:0] c_OP_START  = 2'd0;
    localparam logic [1:0] c_OP_PAUSE  = 2'd1;
    localparam logic [1:0] c_OP_RESUME = 2'd2;
    localparam logic [1:0] c_OP_STOP   = 2'd3;

    localparam logic [1:0] c_EVT_MATCH   = 2'd0;
    localparam logic [1:0] c_EVT_OVF     = 2'd1;
    localparam logic [1:0] c_EVT_TIMEOUT = 2'd2;
    localparam logic [1:0] c_EVT_ILLEGAL = 2'd3;

    localparam int                 c_TMO_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]             r_state, w_state_next;
    logic [c_TMO_W-1:0]     r_tmo;
    logic                   r_start, r_stop, r_pause, r_match_d, r_lost;
    logic [TIMER_WIDTH-1:0] r_load;
    logic [CNT_WIDTH-1:0]   r_match_cnt, r_ovf_cnt;
    logic [1:0]             r_fifo_code [2];
    logic [TIMER_WIDTH-1:0] r_fifo_value [2];
    logic                   r_wr_ptr, r_rd_ptr;
    logic [1:0]             r_count;

    logic                   w_fifo_full, w_fifo_empty, w_pop, w_push, w_push_ok;
    logic                   w_accept, w_match_edge, w_timeout, w_lost_set;
    logic                   w_start, w_stop, w_illegal, w_hw_push, w_inc_match, w_inc_ovf;
    logic [1:0]             w_push_code;
    logic [TIMER_WIDTH-1:0] w_push_value;

    assign w_fifo_full  = (r_count == 2'd2);
    assign w_fifo_empty = (r_count == 2'd0);
    assign w_pop        = !w_fifo_empty && evt_ready;
    assign cmd_ready    = ((r_state == c_IDLE) || (r_state == c_RUNNING) ||
                           (r_state == c_PAUSED)) && !w_fifo_full;
    assign w_accept     = cmd_valid && cmd_ready;
    assign w_match_edge = timer_match && !r_match_d;
    assign w_timeout    = (r_tmo == c_TMO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Overflow outranks any command accepted in the same RUNNING cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept && cmd_op == c_OP_START) w_state_next = c_WAIT_ACT;
            end
            c_WAIT_ACT: begin
                if (timer_active)   w_state_next = c_RUNNING;
                else if (w_timeout) w_state_next = c_IDLE;
            end
            c_RUNNING: begin
                if (timer_overflow)                        w_state_next = c_IDLE;
                else if (w_accept && cmd_op == c_OP_PAUSE) w_state_next = c_PAUSED;
                else if (w_accept && cmd_op == c_OP_STOP)  w_state_next = c_STOPPING;
            end
            c_PAUSED: begin
                if (w_accept && cmd_op == c_OP_RESUME)    w_state_next = c_RUNNING;
                else if (w_accept && cmd_op == c_OP_STOP) w_state_next = c_STOPPING;
            end
            c_STOPPING: begin
                if (!timer_active || w_timeout) w_state_next = c_IDLE;
            end
            default: w_state_next = c_IDLE;
        endcase
    end

    always_comb begin
        w_start      = 1'b0;
        w_stop       = 1'b0;
        w_illegal    = 1'b0;
        w_hw_push    = 1'b0;
        w_inc_match  = 1'b0;
        w_inc_ovf    = 1'b0;
        w_push_code  = c_EVT_MATCH;
        w_push_value = timer_value;
        case (r_state)
            c_IDLE: begin
                w_start   = w_accept && (cmd_op == c_OP_START);
                w_illegal = w_accept && (cmd_op != c_OP_START);
            end
            c_WAIT_ACT: begin
                if (!timer_active && w_timeout) begin
                    w_hw_push   = 1'b1;
                    w_push_code = c_EVT_TIMEOUT;
                end
            end
            c_RUNNING: begin
                w_illegal   = w_accept && (cmd_op == c_OP_START || cmd_op == c_OP_RESUME);
                w_stop      = w_accept && (cmd_op == c_OP_STOP) && !timer_overflow;
                w_inc_match = w_match_edge;
                if (timer_overflow) begin
                    w_hw_push   = 1'b1;
                    w_push_code = c_EVT_OVF;
                    w_inc_ovf   = 1'b1;
                end else if (w_match_edge) begin
                    w_hw_push   = 1'b1;
                    w_push_code = c_EVT_MATCH;
                end
            end
            c_PAUSED: begin
                w_illegal = w_accept && (cmd_op == c_OP_START || cmd_op == c_OP_PAUSE);
                w_stop    = w_accept && (cmd_op == c_OP_STOP);
            end
            c_STOPPING: begin
                if (timer_active && w_timeout) begin
                    w_hw_push   = 1'b1;
                    w_push_code = c_EVT_TIMEOUT;
                end
            end
            default: ;
        endcase
        // A timer event wins the single push slot; a colliding ILLEGAL is counted as lost.
        if (!w_hw_push && w_illegal) begin
            w_push_code  = c_EVT_ILLEGAL;
            w_push_value = TIMER_WIDTH'(cmd_op);
        end
    end

    assign w_push     = w_hw_push || w_illegal;
    assign w_push_ok  = w_push && (!w_fifo_full || w_pop);
    assign w_lost_set = (w_push && !w_push_ok) || (w_hw_push && w_illegal);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_start     <= 1'b0;
            r_stop      <= 1'b0;
            r_pause     <= 1'b0;
            r_match_d   <= 1'b0;
            r_lost      <= 1'b0;
            r_load      <= '0;
            r_tmo       <= '0;
            r_match_cnt <= '0;
            r_ovf_cnt   <= '0;
        end else begin
            r_start   <= w_start;
            r_stop    <= w_stop;
            r_pause   <= (w_state_next == c_PAUSED);
            r_match_d <= timer_match;
            if (w_start) r_load <= cmd_data;
            if (w_state_next != r_state)
                r_tmo <= '0;
            else if (r_state == c_WAIT_ACT || r_state == c_STOPPING)
                r_tmo <= r_tmo + c_TMO_W'(1);
            if (w_inc_match && r_match_cnt != {CNT_WIDTH{1'b1}})
                r_match_cnt <= r_match_cnt + CNT_WIDTH'(1);
            if (w_inc_ovf && r_ovf_cnt != {CNT_WIDTH{1'b1}})
                r_ovf_cnt <= r_ovf_cnt + CNT_WIDTH'(1);
            if (w_lost_set) r_lost <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr        <= 1'b0;
            r_rd_ptr        <= 1'b0;
            r_count         <= 2'd0;
            r_fifo_code[0]  <= 2'd0;
            r_fifo_code[1]  <= 2'd0;
            r_fifo_value[0] <= '0;
            r_fifo_value[1] <= '0;
        end else begin
            if (w_push_ok) begin
                r_fifo_code[r_wr_ptr]  <= w_push_code;
                r_fifo_value[r_wr_ptr] <= w_push_value;
                r_wr_ptr               <= ~r_wr_ptr;
            end
            if (w_pop) r_rd_ptr <= ~r_rd_ptr;
            r_count <= r_count + 2'(w_push_ok) - 2'(w_pop);
        end
    end

    assign timer_load  = r_load;
    assign timer_start = r_start;
    assign timer_stop  = r_stop;
    assign timer_pause = r_pause;
    assign evt_valid   = !w_fifo_empty;
    assign evt_code    = r_fifo_code[r_rd_ptr];
    assign evt_value   = r_fifo_value[r_rd_ptr];
    assign match_count = r_match_cnt;
    assign ovf_count   = r_ovf_cnt;
    assign evt_lost    = r_lost;

endmodule
`default_nettype wire

// File: doc/timer_sequencer.md
TIMER_SEQUENCER -- requirements
Module: timer_sequencer

Interface
REQ-001 SHALL have parameter TIMER_WIDTH, default 32, width of timer load/value buses.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of the match/overflow event counters.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, handshake wait limit in clk cycles.
REQ-004 SHALL have ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when both high
- cmd_op  in  2  00 START, 01 PAUSE, 10 RESUME, 11 STOP
- cmd_data  in  TIMER_WIDTH  load value, START only
- timer_load  out  TIMER_WIDTH  load value to timer
- timer_start  out  1  one-cycle start pulse
- timer_stop  out  1  one-cycle stop pulse
- timer_pause  out  1  pause level
- timer_value  in  TIMER_WIDTH  timer count
- timer_active  in  1  timer running
- timer_match  in  1  timer match flag
- timer_overflow  in  1  timer overflow pulse
- evt_valid  out  1  event available
- evt_ready  in  1  event consumed when both high
- evt_code  out  2  00 MATCH, 01 OVERFLOW, 10 TIMEOUT, 11 ILLEGAL
- evt_value  out  TIMER_WIDTH  timer_value captured with the event
- match_count  out  CNT_WIDTH  saturating count of MATCH detections
- ovf_count  out  CNT_WIDTH  saturating count of overflows
- evt_lost  out  1  sticky, event dropped

Function
REQ-005 SHALL implement FSM states IDLE, WAIT_ACT, RUNNING, PAUSED, STOPPING.
REQ-006 SHALL drive cmd_ready=1 in IDLE, RUNNING and PAUSED when the event FIFO is not full, and 0 otherwise.
REQ-007 On IDLE+START accept: SHALL register timer_load<=cmd_data, pulse timer_start high for exactly the next cycle, and enter WAIT_ACT.
REQ-008 In WAIT_ACT: SHALL enter RUNNING on timer_active=1, otherwise after TIMEOUT_CYCLES cycles SHALL push TIMEOUT and return to IDLE.
REQ-009 On RUNNING+PAUSE accept: SHALL assert timer_pause from the next cycle and enter PAUSED.
REQ-010 In PAUSED, timer_pause SHALL stay 1.
REQ-011 On PAUSED+RESUME accept: SHALL deassert timer_pause the next cycle and enter RUNNING.
REQ-012 On RUNNING or PAUSED + STOP accept: SHALL pulse timer_stop one cycle, deassert timer_pause, and enter STOPPING.
REQ-013 In STOPPING: SHALL enter IDLE on timer_active=0, or on timeout after pushing TIMEOUT.
REQ-014 Any other op/state combination accepted SHALL push ILLEGAL with evt_value=zero-extended cmd_op and SHALL leave state and timer outputs unchanged.
REQ-015 In RUNNING: a 0->1 edge of timer_match SHALL push MATCH with evt_value=timer_value and increment match_count.
REQ-016 timer_overflow=1 in RUNNING SHALL push OVERFLOW with evt_value=timer_value, increment ovf_count, and enter IDLE.
REQ-017 At most one push per cycle; when a match edge and an overflow coincide, SHALL push OVERFLOW only and still increment match_count.
REQ-018 Events SHALL pass through a 2-entry FIFO; evt_valid=1 when it is non-empty; evt_code/evt_value come from the head; pop on evt_valid&evt_ready.
REQ-019 Push into a full FIFO SHALL drop the event and set evt_lost; simultaneous pop and push on a full FIFO SHALL succeed.
REQ-020 Counters SHALL saturate at all-ones and never wrap.
REQ-021 The timeout counter SHALL clear on every state entry.

Reset
REQ-022 On rst: state IDLE; timer_start, timer_stop, timer_pause, evt_valid, evt_lost = 0; timer_load, match_count, ovf_count = 0; FIFO empty; timeout counter 0.
REQ-023 Reset asserted mid-operation SHALL apply REQ-022 immediately and discard all queued events.

Verification
REQ-024 START with cmd_data=0x10, timer_active rises 3 cycles later -> timer_load=0x10, a single timer_start pulse, state RUNNING, no events.
REQ-025 RUNNING, then PAUSE, RESUME, STOP -> timer_pause high from the cycle after PAUSE until the cycle after RESUME; one timer_stop pulse; IDLE once timer_active=0.
REQ-026 START with timer_active held 0 -> TIMEOUT event after 1024 cycles, state IDLE.
REQ-027 timer_match rises with timer_value=0x20, then timer_overflow with value 0xFFFFFFFF -> MATCH(0x20) then OVERFLOW(0xFFFFFFFF); match_count=1, ovf_count=1; state IDLE.
REQ-028 evt_ready=0 with three ILLEGAL commands (RESUME in IDLE) -> two queued, cmd_ready drops when the FIFO is full, evt_lost=0; match and overflow in the same cycle -> single OVERFLOW event.
REQ-029 rst pulsed in PAUSED with 2 queued events -> timer_pause=0, evt_valid=0, counters 0, state IDLE.
